// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-capable arbiter sharing one FIFO write port among NREQ producers.
// Grants are combinational; the FIFO strobe and data are registered one cycle later.
module fifo_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int BURST = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       grant,
    output logic [IDW-1:0]        owner_id,
    output logic                  fifo_we,
    output logic [WIDTH-1:0]      fifo_din,
    input  logic [WIDTH-1:0]      fifo_count
);

    localparam int BW = $clog2(BURST + 1);
    localparam logic [WIDTH:0] FIFO_SIZE = (WIDTH + 1)'(1) << DEPTH;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t          state, state_n;
    logic [IDW-1:0]  ptr, ptr_n, owner_n, winner, gidx;
    logic [BW-1:0]   bcnt, bcnt_n;
    logic            found, space_ok;
    logic [NREQ-1:0] grant_w;
    logic [WIDTH:0]  occupancy;

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
    endfunction

    // The in-flight write is counted so a word registered this cycle cannot overflow.
    always_comb begin
        occupancy = {1'b0, fifo_count} + (WIDTH + 1)'(fifo_we);
        space_ok  = occupancy < FIFO_SIZE;
    end

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[j]) begin
                found  = 1'b1;
                winner = IDW'(j);
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner_id;
        bcnt_n  = bcnt;
        grant_w = '0;
        gidx    = owner_id;
        case (state)
            S_IDLE: begin
                gidx = winner;
                if (found && space_ok) begin
                    grant_w[winner] = 1'b1;
                    owner_n         = winner;
                    bcnt_n          = BW'(1);
                    if (BURST > 1) state_n = S_BURST;
                    else           ptr_n   = next_idx(winner);
                end
            end
            S_BURST: begin
                if (!req[owner_id]) begin
                    ptr_n   = next_idx(owner_id);
                    state_n = S_IDLE;
                end else if (space_ok) begin
                    grant_w[owner_id] = 1'b1;
                    bcnt_n            = bcnt + 1'b1;
                    if (int'(bcnt) + 1 == BURST) begin
                        ptr_n   = next_idx(owner_id);
                        state_n = S_IDLE;
                    end
                end
                // a full FIFO holds the burst without forfeiting ownership
            end
            default: state_n = S_IDLE;
        endcase
        if (reset) grant_w = '0;
    end

    assign grant = grant_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            ptr      <= '0;
            owner_id <= '0;
            bcnt     <= '0;
            fifo_we  <= 1'b0;
            fifo_din <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            owner_id <= owner_n;
            bcnt     <= bcnt_n;
            fifo_we  <= |grant_w;
            if (|grant_w) fifo_din <= req_data[gidx*WIDTH +: WIDTH];
        end
    end

endmodule
